controlador_interrupcao: RTL and testbench

Interrupt source/controller for the single-cycle CPU. It raises the preemption (clock) and halt interrupts that the CPU consumes, latches the cause code and the interrupted PC, and holds them until the CPU acknowledges with its get-interruption control signal. It sits beside the PC and control unit: its pulses force the next PC to 0, and its cause and saved-PC outputs feed the register-file write multiplexer.

---
 rtl/controlador_interrupcao_pkg.sv | 19 +
 rtl/controlador_interrupcao_contador_quantum.sv | 50 +++++
 rtl/controlador_interrupcao.sv | 121 ++++++++++++
 tb/tb_controlador_interrupcao.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_interrupcao_pkg.sv
// Shared constants and types for the interrupt controller: cause codes,
// controller states and default widths.
package controlador_interrupcao_pkg;

  localparam int unsigned QUANTUM_W_DEF = 16;
  localparam int unsigned PC_W_DEF      = 11;
  localparam int unsigned CAUSA_W       = 32;

  localparam logic [CAUSA_W-1:0] CAUSA_NENHUMA = 32'd0;
  localparam logic [CAUSA_W-1:0] CAUSA_CLOCK   = 32'd1;
  localparam logic [CAUSA_W-1:0] CAUSA_HALT    = 32'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } estado_e;

endpackage

// File: rtl/controlador_interrupcao_contador_quantum.sv
// One-shot loadable down-counter for the time slice. Clear beats load, and load
// beats expiry; hold parks the counter at 1 instead of expiring.
module contador_quantum #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         clear,
  input  logic         hold,
  output logic         armed,
  output logic         armed_next_c,
  output logic         expire_c
);

  logic [W-1:0] count;
  logic [W-1:0] count_n;
  logic         armed_n;
  logic         at_one;

  always_comb begin
    at_one   = (count == W'(1));
    expire_c = armed && at_one && !hold && !load;
    count_n  = count;
    armed_n  = armed;
    if (clear) begin
      count_n = '0;
      armed_n = 1'b0;
    end else if (load) begin
      count_n = value;
      armed_n = (value != '0);
    end else if (armed && !(at_one && hold)) begin
      count_n = count - W'(1);
      if (at_one) armed_n = 1'b0;
    end
    armed_next_c = armed_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      armed <= 1'b0;
    end else begin
      count <= count_n;
      armed <= armed_n;
    end
  end

endmodule

// File: rtl/controlador_interrupcao.sv
// Interrupt controller: time-slice and halt interrupts with cause/PC latches.
// Optional macro INT_KERNEL_GUARD_EN defers timer expiry while PC is in kernel space.
module controlador_interrupcao
  import controlador_interrupcao_pkg::*;
#(
  parameter int unsigned QUANTUM_W = QUANTUM_W_DEF,
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] KERNEL_LIMIT = PC_W'(512)
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Halt,
  input  logic                 SetClock,
  input  logic [QUANTUM_W-1:0] TimeSlice,
  input  logic [PC_W-1:0]      PC,
  input  logic                 GetInterruption,
  output logic                 IntHalt,
  output logic                 IntClk,
  output logic                 Pending,
  output logic [CAUSA_W-1:0]   Cause,
  output logic [PC_W-1:0]      SavedPC
);

`ifdef INT_KERNEL_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ARMED   = ARMED;
  localparam logic [1:0] S_PENDING = PENDING;

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic               halt_q;
  logic               halt_rise_c;
  logic               hold_c;
  logic               timer_ok_c;
  logic               armed;
  logic               armed_next_c;
  logic               expire_c;
  logic               int_halt_n;
  logic               int_clk_n;
  logic [CAUSA_W-1:0] cause_n;
  logic [PC_W-1:0]    saved_n;

  assign halt_rise_c = Halt && !halt_q;
  assign hold_c      = GUARD_ON && (PC < KERNEL_LIMIT);

  contador_quantum #(.W(QUANTUM_W)) u_contador (
    .clk          (Clock),
    .rst_n        (ResetN),
    .load         (SetClock),
    .value        (TimeSlice),
    .clear        (halt_rise_c),
    .hold         (hold_c),
    .armed        (armed),
    .armed_next_c (armed_next_c),
    .expire_c     (expire_c)
  );

  // Priority: halt, then timer (dropped under a pending halt), then acknowledge.
  always_comb begin
    state_n    = state;
    int_halt_n = 1'b0;
    int_clk_n  = 1'b0;
    cause_n    = Cause;
    saved_n    = SavedPC;
    timer_ok_c = 1'b1;

    if (state == S_PENDING) timer_ok_c = (Cause != CAUSA_HALT);

    if (halt_rise_c) begin
      int_halt_n = 1'b1;
      cause_n    = CAUSA_HALT;
    end else if (expire_c && timer_ok_c) begin
      int_clk_n  = 1'b1;
      cause_n    = CAUSA_CLOCK;
      saved_n    = PC;
    end else if (GetInterruption) begin
      cause_n    = CAUSA_NENHUMA;
    end

    case (state)
      S_IDLE, S_ARMED: begin
        if (cause_n != CAUSA_NENHUMA) state_n = S_PENDING;
        else                          state_n = armed_next_c ? S_ARMED : S_IDLE;
      end
      S_PENDING: begin
        if (cause_n == CAUSA_NENHUMA) state_n = armed_next_c ? S_ARMED : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= S_IDLE;
      halt_q  <= 1'b0;
      IntHalt <= 1'b0;
      IntClk  <= 1'b0;
      Pending <= 1'b0;
      Cause   <= CAUSA_NENHUMA;
      SavedPC <= '0;
    end else begin
      state   <= state_n;
      halt_q  <= Halt;
      IntHalt <= int_halt_n;
      IntClk  <= int_clk_n;
      Pending <= (cause_n != CAUSA_NENHUMA);
      Cause   <= cause_n;
      SavedPC <= saved_n;
    end
  end

  // Armed is tracked by the counter; the FSM only mirrors it when nothing is pending.
  logic unused_ok;
  assign unused_ok = armed;

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Directed bench for controlador_interrupcao with a deadline-based reference
// model checked every cycle, plus literal expectations per scenario.
module tb_controlador_interrupcao;

`ifdef INT_KERNEL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 512;

  logic        Clock;
  logic        ResetN;
  logic        Halt;
  logic        SetClock;
  logic [15:0] TimeSlice;
  logic [10:0] PC;
  logic        GetInterruption;
  logic        IntHalt;
  logic        IntClk;
  logic        Pending;
  logic [31:0] Cause;
  logic [10:0] SavedPC;

  int checks = 0;
  int errors = 0;

  controlador_interrupcao dut (
    .Clock           (Clock),
    .ResetN          (ResetN),
    .Halt            (Halt),
    .SetClock        (SetClock),
    .TimeSlice       (TimeSlice),
    .PC              (PC),
    .GetInterruption (GetInterruption),
    .IntHalt         (IntHalt),
    .IntClk          (IntClk),
    .Pending         (Pending),
    .Cause           (Cause),
    .SavedPC         (SavedPC)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: the timer is a deadline in absolute edge numbers.
  longint      m_edge;
  longint      m_deadline;
  bit          m_armed;
  bit          m_prev_halt;
  bit          m_ih;
  bit          m_ic;
  logic [31:0] m_cause;
  logic [10:0] m_saved;

  always @(posedge Clock or negedge ResetN) begin : model
    bit rise;
    bit fire;
    if (!ResetN) begin
      m_armed = 0; m_prev_halt = 0; m_ih = 0; m_ic = 0;
      m_cause = 0; m_saved = 0; m_deadline = 0;
    end else begin
      m_edge++;
      rise = Halt && !m_prev_halt;
      m_prev_halt = Halt;
      fire = m_armed && !SetClock && (m_edge >= m_deadline) && (!GUARD || int'(PC) >= LIMIT);
      m_ih = 0;
      m_ic = 0;
      if (rise) begin
        m_ih = 1; m_cause = 2; m_armed = 0;
      end else begin
        if (SetClock) begin
          m_armed = (TimeSlice != 0);
          m_deadline = m_edge + longint'(TimeSlice);
        end else if (fire) begin
          m_armed = 0;
          if (m_cause != 2) begin
            m_ic = 1; m_cause = 1; m_saved = PC;
          end
        end
        if (!m_ic && GetInterruption) m_cause = 0;
      end
    end
  end

  always @(negedge Clock) begin
    if (ResetN) begin
      chk("model_IntHalt", 32'(IntHalt), 32'(m_ih));
      chk("model_IntClk",  32'(IntClk),  32'(m_ic));
      chk("model_Pending", 32'(Pending), 32'(m_cause != 0));
      chk("model_Cause",   Cause,        m_cause);
      chk("model_SavedPC", 32'(SavedPC), 32'(m_saved));
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic set_clock(input int n);
    SetClock = 1'b1;
    TimeSlice = 16'(n);
    tick();
    SetClock = 1'b0;
  endtask

  task automatic ack();
    GetInterruption = 1'b1;
    tick();
    GetInterruption = 1'b0;
  endtask

  // Count pulses over n edges; ic_at is the 1-based edge of the first IntClk.
  task automatic run(input int n, output int ic_cnt, output int ic_at, output int ih_cnt);
    ic_cnt = 0; ic_at = 0; ih_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (IntClk) begin
        ic_cnt++;
        if (ic_at == 0) ic_at = i;
      end
      if (IntHalt) ih_cnt++;
    end
  endtask

  int ic_cnt, ic_at, ih_cnt;

  initial begin
    m_edge = 0;
    ResetN = 1'b0; Halt = 1'b0; SetClock = 1'b0; TimeSlice = '0;
    PC = '0; GetInterruption = 1'b0;
    tick(); tick();
    chk("rst_IntHalt", 32'(IntHalt), 0);
    chk("rst_IntClk",  32'(IntClk),  0);
    chk("rst_Pending", 32'(Pending), 0);
    chk("rst_Cause",   Cause,        0);
    chk("rst_SavedPC", 32'(SavedPC), 0);
    ResetN = 1'b1;
    tick();

    // Timer fire
    PC = 11'd700;
    set_clock(5);
    run(8, ic_cnt, ic_at, ih_cnt);
    chk("fire_count", 32'(ic_cnt), 1);
    chk("fire_edge",  32'(ic_at),  5);
    chk("fire_cause", Cause, 1);
    chk("fire_pc",    32'(SavedPC), 700);
    chk("fire_pend",  32'(Pending), 1);
    ack();
    chk("ack_cause", Cause, 0);
    chk("ack_pend",  32'(Pending), 0);
    chk("ack_pc",    32'(SavedPC), 700);

    // Halt on the expiry edge
    PC = 11'd300;
    set_clock(3);
    tick(); tick();
    Halt = 1'b1;
    tick();
    chk("prio_inthalt", 32'(IntHalt), 1);
    chk("prio_intclk",  32'(IntClk),  0);
    chk("prio_cause",   Cause, 2);
    chk("prio_pc",      32'(SavedPC), 700);
    Halt = 1'b0;
    run(6, ic_cnt, ic_at, ih_cnt);
    chk("prio_no_late_clk", 32'(ic_cnt), 0);
    ack();

    // Held halt overrides a pending clock cause; expiry under halt is dropped
    PC = 11'd400;
    set_clock(2);
    run(2, ic_cnt, ic_at, ih_cnt);
    chk("c1_edge",  32'(ic_at), 2);
    chk("c1_cause", Cause, 1);
    chk("c1_pc",    32'(SavedPC), 400);
    Halt = 1'b1;
    run(10, ic_cnt, ic_at, ih_cnt);
    chk("held_halt_pulses", 32'(ih_cnt), 1);
    chk("held_cause",       Cause, 2);
    Halt = 1'b0;
    set_clock(2);
    run(4, ic_cnt, ic_at, ih_cnt);
    chk("drop_pulses", 32'(ic_cnt), 0);
    chk("drop_cause",  Cause, 2);
    ack();
    chk("drop_ack_cause", Cause, 0);

    // Reload and disarm
    PC = 11'd500;
    set_clock(8);
    tick();
    set_clock(3);
    run(6, ic_cnt, ic_at, ih_cnt);
    chk("reload_count", 32'(ic_cnt), 1);
    chk("reload_edge",  32'(ic_at),  3);
    ack();
    set_clock(4);
    tick(); tick();
    set_clock(0);
    run(8, ic_cnt, ic_at, ih_cnt);
    chk("disarm_pulses", 32'(ic_cnt), 0);
    chk("disarm_pend",   32'(Pending), 0);

    // Ack colliding with halt, then async reset mid-count
    Halt = 1'b1; GetInterruption = 1'b1;
    tick();
    Halt = 1'b0; GetInterruption = 1'b0;
    chk("coll_cause",   Cause, 2);
    chk("coll_inthalt", 32'(IntHalt), 1);
    set_clock(6);
    tick(); tick();
    #2 ResetN = 1'b0;
    #1;
    chk("arst_cause",   Cause, 0);
    chk("arst_pend",    32'(Pending), 0);
    chk("arst_pc",      32'(SavedPC), 0);
    chk("arst_inthalt", 32'(IntHalt), 0);
    chk("arst_intclk",  32'(IntClk), 0);
    #1 ResetN = 1'b1;
    tick();
    run(10, ic_cnt, ic_at, ih_cnt);
    chk("arst_no_fire", 32'(ic_cnt), 0);
    chk("arst_cause_after", Cause, 0);

    // Expiry at a low PC
    PC = 11'd100;
    set_clock(2);
    tick(); tick();
`ifdef INT_KERNEL_GUARD_EN
    chk("guard_deferred", 32'(IntClk), 0);
    chk("guard_pend",     32'(Pending), 0);
    tick(); tick(); tick();
    PC = 11'd600;
    tick();
    chk("guard_fire",  32'(IntClk), 1);
    chk("guard_pc",    32'(SavedPC), 600);
    chk("guard_cause", Cause, 1);
`else
    chk("lowpc_fire",  32'(IntClk), 1);
    chk("lowpc_pc",    32'(SavedPC), 100);
    chk("lowpc_cause", Cause, 1);
`endif
    ack();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
